// File: rtl/apresenta_sequencia_if.sv
// Handshake and memory bus between the game controller, the sequence memory
// and the sequence player.
interface apresenta_sequencia_if #(
  parameter int ADDR_W = 4
) ();
  logic              iniciar;
  logic              cancelar;
  logic              dificuldade;
  logic [ADDR_W-1:0] tamanho;
  logic [7:0]        mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic [7:0]        leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, cancelar, dificuldade, tamanho, mem_dado,
    input  mem_endereco, leds, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, cancelar, dificuldade, tamanho, mem_dado,
    output mem_endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/apresenta_sequencia.sv
// Plays the stored colour sequence on the LEDs: each item lit for TON_EF
// cycles followed by a dark gap of TOFF_EF cycles, then a one-cycle pronto.
module apresenta_sequencia #(
  parameter int T_ON   = 25000000,
  parameter int T_OFF  = 12500000,
  parameter int ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  apresenta_sequencia_if.slave  bus
);
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX + 1);

  // Terminal timer values: the timer counts 0..limit, so limit = duration-1.
  localparam logic [TW-1:0] ON_FULL_LIM  = TW'(T_ON - 1);
  localparam logic [TW-1:0] ON_HALF_LIM  = TW'((T_ON / 2) - 1);
  localparam logic [TW-1:0] OFF_FULL_LIM = TW'(T_OFF - 1);
  localparam logic [TW-1:0] OFF_HALF_LIM = TW'((T_OFF / 2) - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    BUSCA   = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] tam_q, tam_d;
  logic              dif_q, dif_d;
  logic [7:0]        leds_q, leds_d;
  logic              pronto_q, pronto_d;
  logic              ocupado_q, ocupado_d;
  logic [TW-1:0]     lim_on_s, lim_off_s;

  // Next-state and next-output logic for the playback FSM.
  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q + TW'(1);
    end_d     = end_q;
    tam_d     = tam_q;
    dif_d     = dif_q;
    leds_d    = leds_q;
    lim_on_s  = ON_FULL_LIM;
    lim_off_s = OFF_FULL_LIM;

    if (dif_q) begin
      lim_on_s  = ON_HALF_LIM;
      lim_off_s = OFF_HALF_LIM;
    end else begin
      lim_on_s  = ON_FULL_LIM;
      lim_off_s = OFF_FULL_LIM;
    end

    if (bus.cancelar) begin
      estado_d = OCIOSO;
      leds_d   = 8'h00;
      end_d    = '0;
      timer_d  = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          leds_d  = 8'h00;
          timer_d = '0;
          if (bus.iniciar) begin
            tam_d    = bus.tamanho;
            dif_d    = bus.dificuldade;
            end_d    = '0;
            estado_d = BUSCA;
          end else begin
            estado_d = OCIOSO;
          end
        end
        BUSCA: begin
          leds_d   = bus.mem_dado;
          timer_d  = '0;
          estado_d = ACESO;
        end
        ACESO: begin
          if (timer_q == lim_on_s) begin
            leds_d   = 8'h00;
            timer_d  = '0;
            estado_d = APAGADO;
          end else begin
            estado_d = ACESO;
          end
        end
        APAGADO: begin
          leds_d = 8'h00;
          if (timer_q == lim_off_s) begin
            timer_d = '0;
            // Stop at the latched last index; the address never wraps.
            if (end_q == tam_q) begin
              estado_d = FIM;
            end else begin
              end_d    = end_q + ADDR_W'(1);
              estado_d = BUSCA;
            end
          end else begin
            estado_d = APAGADO;
          end
        end
        FIM: begin
          leds_d   = 8'h00;
          timer_d  = '0;
          estado_d = OCIOSO;
        end
        default: begin
          leds_d   = 8'h00;
          timer_d  = '0;
          end_d    = '0;
          estado_d = OCIOSO;
        end
      endcase
    end

    pronto_d  = (estado_d == FIM);
    ocupado_d = (estado_d != OCIOSO);
  end

  // State and registered-output update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      timer_q   <= '0;
      end_q     <= '0;
      tam_q     <= '0;
      dif_q     <= 1'b0;
      leds_q    <= 8'h00;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      end_q     <= end_d;
      tam_q     <= tam_d;
      dif_q     <= dif_d;
      leds_q    <= leds_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.mem_endereco = end_q;
  assign bus.leds         = leds_q;
  assign bus.pronto       = pronto_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.db_estado    = estado_q;
endmodule

// File: tb/tb_apresenta_sequencia.sv
// Bench for apresenta_sequencia: directed table of runs plus randomized runs,
// all compared cycle by cycle against a timeline model of the playback.
module tb_apresenta_sequencia;
  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int ADDR_W = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] mem [16];
  int         checks = 0;
  int         errors = 0;

  apresenta_sequencia_if #(.ADDR_W(ADDR_W)) intf ();

  assign intf.mem_dado = mem[intf.mem_endereco];

  apresenta_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] leds;
    logic       pronto;
    logic       ocupado;
    int         estado;
    int         addr;
    bit         chk_addr;
  } exp_t;

  typedef struct {
    int tam;
    bit dif;
    int glitch_at;
    int tchg_at;
    int cancel_at;
    int reset_at;
    int exp_fim;
  } vec_t;

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic int fim_cycle(input int n, input bit dif);
    int ton, toff;
    ton  = dif ? T_ON / 2 : T_ON;
    toff = dif ? T_OFF / 2 : T_OFF;
    return 1 + n * (1 + ton + toff);
  endfunction

  // Expected outputs in cycle c of a run started at edge 0 (cycle c follows edge c-1).
  function automatic exp_t model(input int c, input int n, input bit dif, input int cancel_at);
    exp_t e;
    int   ton, p, o, i, r, fc;
    ton = dif ? T_ON / 2 : T_ON;
    p   = 1 + ton + (dif ? T_OFF / 2 : T_OFF);
    fc  = fim_cycle(n, dif);
    e   = '{leds: 8'h00, pronto: 1'b0, ocupado: 1'b0, estado: 0, addr: 0, chk_addr: 1'b0};
    if (cancel_at > 0 && c > cancel_at) begin
      e.chk_addr = 1'b1;
      return e;
    end
    if (c < 1 || c > fc) return e;
    e.ocupado  = 1'b1;
    e.chk_addr = 1'b1;
    if (c == fc) begin
      e.estado = 4;
      e.pronto = 1'b1;
      e.addr   = n - 1;
      return e;
    end
    o = c - 1;
    i = o / p;
    r = o % p;
    e.addr = i;
    if (r == 0) begin
      e.estado = 1;
    end else if (r <= ton) begin
      e.estado = 2;
      e.leds   = mem[i];
    end else begin
      e.estado = 3;
    end
    return e;
  endfunction

  task automatic check_reset_values(input int c);
    chk("rst_leds",    c, intf.leds,         0);
    chk("rst_estado",  c, intf.db_estado,    0);
    chk("rst_pronto",  c, intf.pronto,       0);
    chk("rst_ocupado", c, intf.ocupado,      0);
    chk("rst_addr",    c, intf.mem_endereco, 0);
  endtask

  task automatic run_case(input int tam, input bit dif, input int glitch_at, input int tchg_at,
                          input int cancel_at, input int reset_at, input bit rnd,
                          output int fim_seen);
    int   n, last;
    exp_t e;
    n        = tam + 1;
    last     = (cancel_at > 0) ? cancel_at + 3 : fim_cycle(n, dif) + 2;
    fim_seen = 0;
    @(negedge clock);
    chk("idle_estado",  0, intf.db_estado, 0);
    chk("idle_ocupado", 0, intf.ocupado,   0);
    intf.iniciar     = 1'b1;
    intf.cancelar    = 1'b0;
    intf.tamanho     = 4'(tam);
    intf.dificuldade = dif;
    @(posedge clock);
    for (int c = 1; c <= last; c++) begin
      @(negedge clock);
      e = model(c, n, dif, cancel_at);
      chk("leds",    c, intf.leds,      e.leds);
      chk("pronto",  c, intf.pronto,    e.pronto);
      chk("ocupado", c, intf.ocupado,   e.ocupado);
      chk("estado",  c, intf.db_estado, e.estado);
      if (e.chk_addr) chk("addr", c, intf.mem_endereco, e.addr);
      if (intf.pronto) fim_seen = c;
      if (c == reset_at) begin
        intf.iniciar = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values(c);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      intf.cancelar    = (c == cancel_at);
      intf.iniciar     = (c == glitch_at);
      intf.tamanho     = (tchg_at > 0 && c >= tchg_at) ? 4'd0 : 4'(tam);
      intf.dificuldade = dif;
      if (rnd) begin
        intf.tamanho     = 4'($urandom_range(0, 15));
        intf.dificuldade = 1'($urandom_range(0, 1));
        if (e.ocupado) intf.iniciar = 1'($urandom_range(0, 1));
      end
    end
    intf.iniciar  = 1'b0;
    intf.cancelar = 1'b0;
  endtask

  initial begin
    vec_t vt[10];
    int   fim, tam, fc, cancel_at;
    bit   dif;

    reset            = 1'b0;
    intf.iniciar     = 1'b0;
    intf.cancelar    = 1'b0;
    intf.dificuldade = 1'b0;
    intf.tamanho     = 4'd0;
    mem[0] = 8'h01;
    mem[1] = 8'h04;
    mem[2] = 8'h80;
    mem[3] = 8'h00;
    for (int i = 4; i < 16; i++) mem[i] = 8'(i * 37);

    repeat (2) @(negedge clock);
    check_reset_values(0);
    reset = 1'b1;

    //          tam dif glitch tchg cancel reset exp_fim
    vt[0] = '{ 2, 1'b0,  0, 0,  0,  0,  22};
    vt[1] = '{ 2, 1'b1,  0, 0,  0,  0,  13};
    vt[2] = '{ 0, 1'b0,  0, 0,  0,  0,   8};
    vt[3] = '{ 2, 1'b0, 10, 3,  0,  0,  22};
    vt[4] = '{ 2, 1'b0,  0, 0, 10,  0,   0};
    vt[5] = '{ 2, 1'b0,  0, 0,  0,  0,  22};
    vt[6] = '{ 2, 1'b0,  0, 0,  0, 14,   0};
    vt[7] = '{ 2, 1'b0,  0, 0,  0,  0,  22};
    vt[8] = '{15, 1'b0,  0, 0,  0,  0, 113};
    vt[9] = '{15, 1'b1,  0, 0,  0,  0,  65};

    for (int i = 0; i < 10; i++) begin
      run_case(vt[i].tam, vt[i].dif, vt[i].glitch_at, vt[i].tchg_at,
               vt[i].cancel_at, vt[i].reset_at, 1'b0, fim);
      chk("fim_cycle", i, fim, vt[i].exp_fim);
    end

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      tam       = $urandom_range(0, 7);
      dif       = 1'($urandom_range(0, 1));
      fc        = fim_cycle(tam + 1, dif);
      cancel_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, fc) : 0;
      run_case(tam, dif, 0, 0, cancel_at, 0, 1'b1, fim);
      chk("rnd_fim", k, fim, (cancel_at > 0 && cancel_at < fc) ? 0 : fc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
